// File: rtl/guess_entry_ctrl_if.sv
// guess_entry_ctrl_if
//   Bundles the keyboard strobes, the word_db lookup pair and the guess
//   result outputs of guess_entry_ctrl into one interface.
//   slave  : the controller side (takes keys and db_in_db, drives the rest)
//   master : the environment side (keyboard decoder, word_db, game logic)
// Signals
//   clear        start new game (sync)
//   key_valid    letter strobe; key_code 0='a'..25='z', 26..31 illegal
//   key_del      backspace strobe
//   key_enter    submit strobe
//   db_word      word presented to word_db, letter i at [5i+4:5i]
//   db_in_db     word_db membership result (combinational from db_word)
//   cur_len      letters currently buffered, 0..5
//   busy         lookup/result in progress, keys ignored
//   guess_valid  one-cycle result strobe
//   guess_accept accept flag, qualified by guess_valid
//   guess_word   last submitted word
//   guess_num    accepted guesses this game
//   game_over    guess limit reached
interface guess_entry_ctrl_if;
  logic        clear;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_del;
  logic        key_enter;
  logic [24:0] db_word;
  logic        db_in_db;
  logic [2:0]  cur_len;
  logic        busy;
  logic        guess_valid;
  logic        guess_accept;
  logic [24:0] guess_word;
  logic [2:0]  guess_num;
  logic        game_over;

  modport slave (
    input  clear, key_valid, key_code, key_del, key_enter, db_in_db,
    output db_word, cur_len, busy, guess_valid, guess_accept,
           guess_word, guess_num, game_over
  );

  modport master (
    output clear, key_valid, key_code, key_del, key_enter, db_in_db,
    input  db_word, cur_len, busy, guess_valid, guess_accept,
           guess_word, guess_num, game_over
  );
endinterface

// File: rtl/guess_entry_ctrl.sv
// guess_entry_ctrl
//   Sequences one Wordle guess: collects typed letters into a 25-bit word,
//   presents it to the word_db bloom filter, samples the membership answer
//   after DB_WAIT cycles and reports accept/reject. Counts accepted guesses
//   per game and locks out further entry once MAX_GUESSES is reached.
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    guess_entry_ctrl_if.slave (keys, db lookup, guess results)
// Parameters
//   MAX_GUESSES  guesses per game before lockout (1..7)
//   DB_WAIT      cycles db_word is held before db_in_db is sampled (1..15)
// Build option
//   REJECT_REPEAT_EN  keeps a per-game history of accepted words and
//                     rejects resubmission of any of them.
module guess_entry_ctrl #(
  parameter int MAX_GUESSES = 6,
  parameter int DB_WAIT     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  guess_entry_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_ENTRY  = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [2:0] MaxNum  = 3'(MAX_GUESSES);
  localparam logic [3:0] WaitCnt = 4'(DB_WAIT);

  logic [1:0]  state_q, state_d;
  logic [24:0] buf_q, buf_d;
  logic [2:0]  len_q, len_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [24:0] gword_q, gword_d;
  logic [2:0]  gnum_q, gnum_d;
  logic        valid_q, valid_d;
  logic        accept_q, accept_d;
  logic        accept_w;

`ifdef REJECT_REPEAT_EN
  logic [24:0]            hist_q [MAX_GUESSES];
  logic [MAX_GUESSES-1:0] hvalid_q;
  logic                   repeat_w;

  // The submitted word is compared against every valid history entry.
  always_comb begin
    repeat_w = 1'b0;
    for (int i = 0; i < MAX_GUESSES; i++)
      if (hvalid_q[i] && hist_q[i] == gword_q) repeat_w = 1'b1;
  end

  assign accept_w = bus.db_in_db & ~repeat_w;

  // History is appended on the RESULT edge of an accepted guess, at the
  // slot indexed by the guess count before it increments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hvalid_q <= '0;
      for (int i = 0; i < MAX_GUESSES; i++) hist_q[i] <= '0;
    end else if (bus.clear) begin
      hvalid_q <= '0;
    end else if (state_q == ST_RESULT && accept_q) begin
      for (int i = 0; i < MAX_GUESSES; i++)
        if (3'(i) == gnum_q) begin
          hist_q[i]   <= gword_q;
          hvalid_q[i] <= 1'b1;
        end
    end
  end
`else
  assign accept_w = bus.db_in_db;
`endif

  // Next-state logic. Clear overrides everything; in ENTRY the key actions
  // are prioritised enter > del > key and only one takes effect per cycle.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    gword_d  = gword_q;
    gnum_d   = gnum_q;
    valid_d  = 1'b0;
    accept_d = accept_q;

    if (bus.clear) begin
      state_d = ST_ENTRY;
      buf_d   = '0;
      len_d   = '0;
      cnt_d   = '0;
      gnum_d  = '0;
    end else begin
      case (state_q)
        ST_ENTRY: begin
          if (bus.key_enter) begin
            if (len_q == 3'd5) begin
              gword_d = buf_q;
              cnt_d   = WaitCnt;
              state_d = ST_LOOKUP;
            end
          end else if (bus.key_del) begin
            if (len_q != 3'd0) begin
              len_d = len_q - 3'd1;
              for (int i = 0; i < 5; i++)
                if (3'(i) == len_d) buf_d[5*i +: 5] = 5'd0;
            end
          end else if (bus.key_valid) begin
            if (bus.key_code <= 5'd25 && len_q < 3'd5) begin
              for (int i = 0; i < 5; i++)
                if (3'(i) == len_q) buf_d[5*i +: 5] = bus.key_code;
              len_d = len_q + 3'd1;
            end
          end
        end
        ST_LOOKUP: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            accept_d = accept_w;
            valid_d  = 1'b1;
            state_d  = ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (accept_q) begin
            buf_d = '0;
            len_d = '0;
            if (gnum_q < MaxNum) gnum_d = gnum_q + 3'd1;
            state_d = (gnum_d == MaxNum) ? ST_DONE : ST_ENTRY;
          end else begin
            state_d = ST_ENTRY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ENTRY;
      buf_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      gword_q  <= '0;
      gnum_q   <= '0;
      valid_q  <= 1'b0;
      accept_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      gword_q  <= gword_d;
      gnum_q   <= gnum_d;
      valid_q  <= valid_d;
      accept_q <= accept_d;
    end
  end

  assign bus.db_word      = buf_q;
  assign bus.cur_len      = len_q;
  assign bus.busy         = (state_q == ST_LOOKUP) || (state_q == ST_RESULT);
  assign bus.guess_valid  = valid_q;
  assign bus.guess_accept = accept_q;
  assign bus.guess_word   = gword_q;
  assign bus.guess_num    = gnum_q;
  assign bus.game_over    = (gnum_q == MaxNum);

endmodule
